fifo_pll_gen2: RTL and testbench

FIFO_PLL_GEN2 -- requirements
Module: fifo_pll_gen2

---
 rtl/fifo_pll_pkg.sv | 22 ++
 rtl/fifo_pll_gen2_mem.sv | 37 +++
 rtl/fifo_pll_gen2.sv | 126 ++++++++++++
 tb/tb_fifo_pll_gen2.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pll_pkg.sv
// rtl/fifo_pll_pkg.sv - shared defaults and width derivation for the fifo_pll_gen2 block
//
// Purpose : holds the default data width and depth, and the functions that
//           derive pointer and fill-level widths from a depth.
// Ports   : none (package)
package fifo_pll_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_DEPTH = 8;

    // Pointer width: addresses 0..depth-1. Depth is a power of two, so
    // pointers wrap by natural overflow.
    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    // Fill-level width: one extra bit so that 0..depth fits.
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_pll_gen2_mem.sv
// rtl/fifo_pll_gen2_mem.sv - FIFO storage array, one write port and one synchronous read port
//
// Purpose : plain register array with no reset. A read and a write to the
//           same address in one cycle return the old contents.
// Ports   : clk      - clock
//           wr_en    - write strobe
//           wr_addr  - write address
//           wr_data  - write data
//           rd_en    - read strobe; rd_data updates only when set
//           rd_addr  - read address
//           rd_data  - registered read data, held when rd_en is low
module fifo_pll_gen2_mem #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fifo_pll_gen2.sv
// rtl/fifo_pll_gen2.sv - synchronous FIFO with registered read data and level flags
//
// Purpose : single-clock FIFO, no fall-through. An accepted read presents
//           the oldest word on data_out one cycle later with a one-cycle
//           data_valid pulse. Optional sticky overflow/underflow flags are
//           compiled in when FIFO_PLL_GEN2_ERR_EN is defined.
// Ports   : clk, rst            - clock, synchronous active-high reset
//           write_enable/data_in - write request and data
//           read_enable          - read request
//           data_out/data_valid  - registered read data and its strobe
//           fifo_full/fifo_empty/almost_full/almost_empty - level flags
//           fill_level           - occupancy 0..DEPTH
//           err_clear/overflow/underflow - only with FIFO_PLL_GEN2_ERR_EN
module fifo_pll_gen2
    import fifo_pll_pkg::*;
#(
    parameter int WIDTH         = DEFAULT_WIDTH,
    parameter int DEPTH         = DEFAULT_DEPTH,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    write_enable,
    input  logic [WIDTH-1:0]        data_in,
    input  logic                    read_enable,
    output logic [WIDTH-1:0]        data_out,
    output logic                    data_valid,
    output logic                    fifo_full,
    output logic                    fifo_empty,
    output logic                    almost_full,
    output logic                    almost_empty,
`ifdef FIFO_PLL_GEN2_ERR_EN
    input  logic                    err_clear,
    output logic                    overflow,
    output logic                    underflow,
`endif
    output logic [lvl_w(DEPTH)-1:0] fill_level
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int LVL_W = lvl_w(DEPTH);

    localparam logic [LVL_W-1:0] FULL_LVL   = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] AFULL_LVL  = LVL_W'(AFULL_THRESH);
    localparam logic [LVL_W-1:0] AEMPTY_LVL = LVL_W'(AEMPTY_THRESH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [WIDTH-1:0] mem_rdata;
    // The storage has no reset, so after reset data_out is forced to zero
    // until the first accepted read reloads the read register.
    logic             out_clr;
    logic             rd_acc;
    logic             wr_acc;

    assign fifo_full    = (fill_level == FULL_LVL);
    assign fifo_empty   = (fill_level == '0);
    assign almost_full  = (fill_level >= AFULL_LVL);
    assign almost_empty = (fill_level <= AEMPTY_LVL);

    assign rd_acc = read_enable && !fifo_empty;
    assign wr_acc = write_enable && (!fifo_full || rd_acc);

    assign data_out = out_clr ? '0 : mem_rdata;

    fifo_pll_gen2_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc && !rst),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_en   (rd_acc && !rst),
        .rd_addr (rd_ptr),
        .rd_data (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
            data_valid <= 1'b0;
            out_clr    <= 1'b1;
        end else begin
            data_valid <= rd_acc;
            if (rd_acc) begin
                rd_ptr  <= rd_ptr + PTR_W'(1);
                out_clr <= 1'b0;
            end
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (wr_acc && !rd_acc) begin
                fill_level <= fill_level + LVL_W'(1);
            end else if (rd_acc && !wr_acc) begin
                fill_level <= fill_level - LVL_W'(1);
            end
        end
    end

`ifdef FIFO_PLL_GEN2_ERR_EN
    // Sticky error flags; a new error in the clear cycle keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (write_enable && !wr_acc) begin
                overflow <= 1'b1;
            end else if (err_clear) begin
                overflow <= 1'b0;
            end
            if (read_enable && !rd_acc) begin
                underflow <= 1'b1;
            end else if (err_clear) begin
                underflow <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_pll_gen2.sv
// tb/tb_fifo_pll_gen2.sv - directed self-checking bench for fifo_pll_gen2
module tb_fifo_pll_gen2;

    logic        clk = 1'b0;
    logic        rst;
    logic        write_enable;
    logic [15:0] data_in;
    logic        read_enable;
    logic [15:0] data_out;
    logic        data_valid;
    logic        fifo_full;
    logic        fifo_empty;
    logic        almost_full;
    logic        almost_empty;
    logic [3:0]  fill_level;
`ifdef FIFO_PLL_GEN2_ERR_EN
    logic        err_clear;
    logic        overflow;
    logic        underflow;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fifo_pll_gen2 #(
        .WIDTH         (16),
        .DEPTH         (8),
        .AFULL_THRESH  (6),
        .AEMPTY_THRESH (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .write_enable (write_enable),
        .data_in      (data_in),
        .read_enable  (read_enable),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
`ifdef FIFO_PLL_GEN2_ERR_EN
        .err_clear    (err_clear),
        .overflow     (overflow),
        .underflow    (underflow),
`endif
        .fill_level   (fill_level)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        write_enable = 1'b0;
        read_enable  = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        write_enable = 1'b0;
        read_enable  = 1'b0;
        data_in      = '0;
`ifdef FIFO_PLL_GEN2_ERR_EN
        err_clear    = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;
        chk("rst_fill",   32'(fill_level), 0);
        chk("rst_empty",  32'(fifo_empty), 1);
        chk("rst_aempty", 32'(almost_empty), 1);
        chk("rst_full",   32'(fifo_full), 0);
        chk("rst_afull",  32'(almost_full), 0);
        chk("rst_dout",   32'(data_out), 0);
        chk("rst_valid",  32'(data_valid), 0);

        // Fill 0x0001..0x0008
        for (int i = 1; i <= 8; i++) begin
            write_enable = 1'b1;
            data_in      = 16'(i);
            tick();
            chk("wr_fill",   32'(fill_level), 32'(i));
            chk("wr_afull",  32'(almost_full), (i >= 6) ? 1 : 0);
            chk("wr_aempty", 32'(almost_empty), (i <= 2) ? 1 : 0);
            chk("wr_valid",  32'(data_valid), 0);
        end
        chk("full_flag", 32'(fifo_full), 1);

        // Ninth write must be rejected
        data_in = 16'h0099;
        tick();
        chk("ovf_fill", 32'(fill_level), 8);
        chk("ovf_full", 32'(fifo_full), 1);

        // Drain 8 in order
        idle();
        for (int i = 1; i <= 8; i++) begin
            read_enable = 1'b1;
            tick();
            chk("rd_data",  32'(data_out), 32'(i));
            chk("rd_valid", 32'(data_valid), 1);
            chk("rd_fill",  32'(fill_level), 32'(8 - i));
        end
        idle();
        tick();
        chk("drain_valid", 32'(data_valid), 0);
        chk("drain_hold",  32'(data_out), 16'h0008);
        chk("drain_empty", 32'(fifo_empty), 1);

        // Refill, then simultaneous read+write on a full FIFO
        for (int i = 1; i <= 8; i++) begin
            write_enable = 1'b1;
            data_in      = 16'(i);
            tick();
        end
        write_enable = 1'b1;
        read_enable  = 1'b1;
        data_in      = 16'h00AA;
        tick();
        chk("rw_full_data",  32'(data_out), 1);
        chk("rw_full_valid", 32'(data_valid), 1);
        chk("rw_full_fill",  32'(fill_level), 8);
        idle();
        tick();
        chk("gap_valid", 32'(data_valid), 0);
        chk("gap_hold",  32'(data_out), 1);
        for (int i = 2; i <= 9; i++) begin
            read_enable = 1'b1;
            tick();
            chk("wrap_data", 32'(data_out), (i == 9) ? 32'h00AA : 32'(i));
        end
        idle();
        tick();
        chk("wrap_empty", 32'(fifo_empty), 1);

        // Empty FIFO, read+write together: no fall-through
        write_enable = 1'b1;
        read_enable  = 1'b1;
        data_in      = 16'h0055;
        tick();
        chk("rw_empty_valid", 32'(data_valid), 0);
        chk("rw_empty_fill",  32'(fill_level), 1);
        chk("rw_empty_hold",  32'(data_out), 16'h00AA);
        write_enable = 1'b0;
        tick();
        chk("rw_empty_data",  32'(data_out), 16'h0055);
        chk("rw_empty_vld2",  32'(data_valid), 1);
        chk("rw_empty_fill2", 32'(fill_level), 0);
        idle();

        // Fill to 6, read one (fill 5, data_out nonzero), then reset mid-stream
        for (int i = 0; i < 6; i++) begin
            write_enable = 1'b1;
            data_in      = 16'(16'h0010 + i);
            tick();
        end
        write_enable = 1'b0;
        read_enable  = 1'b1;
        tick();
        chk("pre_rst_data", 32'(data_out), 16'h0010);
        chk("pre_rst_fill", 32'(fill_level), 5);
        rst          = 1'b1;
        write_enable = 1'b1;
        read_enable  = 1'b1;
        data_in      = 16'h0123;
        tick();
        rst = 1'b0;
        idle();
        chk("mid_rst_fill",  32'(fill_level), 0);
        chk("mid_rst_valid", 32'(data_valid), 0);
        chk("mid_rst_dout",  32'(data_out), 0);
        chk("mid_rst_empty", 32'(fifo_empty), 1);
        chk("mid_rst_afull", 32'(almost_full), 0);

        // Stored data was discarded: next write/read round-trips fresh data
        write_enable = 1'b1;
        data_in      = 16'h0077;
        tick();
        write_enable = 1'b0;
        read_enable  = 1'b1;
        tick();
        chk("post_rst_data", 32'(data_out), 16'h0077);
        chk("post_rst_fill", 32'(fill_level), 0);
        idle();
        tick();

`ifdef FIFO_PLL_GEN2_ERR_EN
        chk("err_init_u", 32'(underflow), 0);
        read_enable = 1'b1;
        tick();
        idle();
        chk("err_udf", 32'(underflow), 1);
        chk("err_ovf_quiet", 32'(overflow), 0);
        tick();
        chk("err_udf_held", 32'(underflow), 1);
        for (int i = 0; i < 8; i++) begin
            write_enable = 1'b1;
            data_in      = 16'(i);
            tick();
        end
        chk("err_ovf_pre", 32'(overflow), 0);
        tick();
        write_enable = 1'b0;
        chk("err_ovf", 32'(overflow), 1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("err_clr_o", 32'(overflow), 0);
        chk("err_clr_u", 32'(underflow), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
